// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO: word width, address width and pointer width.
// Pointers carry one extra wrap bit beyond the address so full and empty can be told apart.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Write/read/status bundle for fifo_sync_param; master drives requests, slave is the FIFO.
// Status flags, count and sticky errors all travel with the bus.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                           wr_en;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic                           rd_en;
  logic                           clr_err;
  logic [DATA_WIDTH-1:0]          rd_data;
  logic                           rd_valid;
  logic                           full;
  logic                           empty;
  logic                           almost_full;
  logic                           almost_empty;
  logic [ptr_width(ADDR_WIDTH)-1:0] count;
  logic                           overflow;
  logic                           underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_sync_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
// Read data follows rd_addr combinationally; a write lands on the rising edge.
module fifo_sync_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Synchronous FIFO with status flags, occupancy count and sticky overflow/underflow; registered read
// (one-cycle latency, rd_valid pulse) by default, first-word fall-through when FIFO_SYNC_PARAM_FWFT_EN is defined.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_sync_param_if.slave bus
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

  if (ADDR_WIDTH < 1 || DEPTH != (1 << ADDR_WIDTH) || AE_LEVEL < 0 ||
      AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_cfg
    $error("fifo_sync_param: illegal parameter set");
  end

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_q;
  logic                  udf_q;
  logic [DATA_WIDTH-1:0] mem_rd;

  // Same address with different wrap bits means the writer is a full lap ahead.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign count  = wr_ptr - rd_ptr;
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      // A fresh error in the clearing cycle keeps the flag set.
      ovf_q <= (bus.wr_en && full)  || (ovf_q && !bus.clr_err);
      udf_q <= (bus.rd_en && empty) || (udf_q && !bus.clr_err);
    end
  end

  fifo_sync_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (bus.wr_data),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (mem_rd)
  );

`ifdef FIFO_SYNC_PARAM_FWFT_EN
  assign bus.rd_data  = mem_rd;
  assign bus.rd_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem_rd;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AF_THR);
  assign bus.almost_empty = (count <= AE_THR);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed scoreboard bench for fifo_sync_param (8-bit words, 8 entries, AF=6, AE=2).
// Works against either read mode depending on FIFO_SYNC_PARAM_FWFT_EN.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fifo_sync_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  fifo_sync_param #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3),
    .DEPTH      (8),
    .AF_LEVEL   (6),
    .AE_LEVEL   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic       ovf_m = 1'b0;
  logic       udf_m = 1'b0;
  logic [7:0] rdd_m = 8'h00;
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive requests, advance the model, then compare every output.
  task automatic cycle(input bit we, input logic [7:0] wd, input bit re,
                       input bit ce, input bit rs);
    bit         full_b;
    bit         empty_b;
    bit         racc;
    logic [7:0] popped;
    full_b  = (q.size() == 8);
    empty_b = (q.size() == 0);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.clr_err = ce;
    rst_n       = !rs;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    rst_n       = 1'b1;
    racc = 1'b0;
    if (rs) begin
      q.delete();
      ovf_m = 1'b0;
      udf_m = 1'b0;
      rdd_m = 8'h00;
    end else begin
      if (re && !empty_b) begin
        popped = q.pop_front();
        racc   = 1'b1;
        rdd_m  = popped;
      end
      if (we && !full_b) q.push_back(wd);
      ovf_m = (we && full_b)  || (ovf_m && !ce);
      udf_m = (re && empty_b) || (udf_m && !ce);
    end
`ifdef FIFO_SYNC_PARAM_FWFT_EN
    chk("rd_valid", bus.rd_valid, q.size() != 0);
    if (q.size() != 0) chk("rd_data", bus.rd_data, q[0]);
`else
    chk("rd_valid", bus.rd_valid, racc);
    chk("rd_data", bus.rd_data, rdd_m);
`endif
    chk("count", bus.count, q.size());
    chk("empty", bus.empty, q.size() == 0);
    chk("full", bus.full, q.size() == 8);
    chk("almost_full", bus.almost_full, q.size() >= 6);
    chk("almost_empty", bus.almost_empty, q.size() <= 2);
    chk("overflow", bus.overflow, ovf_m);
    chk("underflow", bus.underflow, udf_m);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;

    // Reset state
    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0);

    // Fill, overflow attempt, drain in order
    for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 0, 0, 0);
    cycle(1, 8'hFF, 0, 0, 0);
    chk("ovf_after_full_write", bus.overflow, 1'b1);
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 0, 1, 0);
    chk("ovf_cleared", bus.overflow, 1'b0);

    // Almost-full / almost-empty thresholds
    for (int i = 0; i < 6; i++) cycle(1, 8'h10 + 8'(i), 0, 0, 0);
    chk("af_at_6", bus.almost_full, 1'b1);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, 0);
    chk("ae_at_2", bus.almost_empty, 1'b1);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);

    // Half occupancy, then 20 concurrent read+write cycles across the wrap
    for (int i = 0; i < 4; i++) cycle(1, 8'h40 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 8'($urandom_range(0, 255)), 1, 0, 0);
    chk("count_steady", bus.count, 4);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, 0);

    // Underflow, clear, clear racing a new underflow
    cycle(0, 8'h00, 1, 0, 0);
    chk("udf_set", bus.underflow, 1'b1);
    cycle(0, 8'h00, 0, 1, 0);
    cycle(0, 8'h00, 1, 1, 0);
    chk("udf_set_wins", bus.underflow, 1'b1);
    cycle(0, 8'h00, 0, 1, 0);

    // Both requested while empty, then while full
    cycle(1, 8'h77, 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 8'h80 + 8'(i), 0, 0, 0);
    cycle(1, 8'hEE, 1, 0, 0);
    cycle(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 7; i++) cycle(0, 8'h00, 1, 0, 0);

    // Reset mid-operation with a concurrent write
    for (int i = 0; i < 3; i++) cycle(1, 8'h20 + 8'(i), 0, 0, 0);
    cycle(1, 8'h99, 0, 0, 1);
    chk("rst_count", bus.count, 0);
    cycle(1, 8'h5A, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);

    // Single word presented, then idle, then popped
    cycle(1, 8'hA5, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    chk("empty_after_pop", bus.empty, 1'b1);
    cycle(0, 8'h00, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
- REQ-001: Parameter DATA_WIDTH, default 8, SHALL set the data word width in bits.
- REQ-002: Parameter ADDR_WIDTH, default 3, SHALL set log2 of the number of entries.
- REQ-003: Parameter DEPTH, default 1<<ADDR_WIDTH, SHALL set the entry count; no other value is legal.
- REQ-004: Parameter AF_LEVEL, default DEPTH-2, SHALL set the occupancy at or above which almost_full asserts.
- REQ-005: Parameter AE_LEVEL, default 2, SHALL set the occupancy at or below which almost_empty asserts.
- REQ-006: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-007: rst_n  input  1  SHALL be the reset: synchronous, active-low.
- REQ-008: wr_en  input  1  SHALL be the write request.
- REQ-009: wr_data  input  DATA_WIDTH  SHALL be the write data.
- REQ-010: rd_en  input  1  SHALL be the read request (pop/ack in FWFT mode).
- REQ-011: clr_err  input  1  SHALL clear the sticky error flags.
- REQ-012: rd_data  output  DATA_WIDTH  SHALL be the read data.
- REQ-013: rd_valid  output  1  SHALL qualify rd_data.
- REQ-014: full, empty, almost_full, almost_empty  output  1 each  SHALL be the status flags.
- REQ-015: count  output  ADDR_WIDTH+1  SHALL be the current occupancy, 0..DEPTH.
- REQ-016: overflow, underflow  output  1 each  SHALL be the sticky error flags.

Function
- REQ-017: Write accepted iff wr_en && !full; word stored at wr_ptr[ADDR_WIDTH-1:0]; wr_ptr (ADDR_WIDTH+1 bits) increments, wrapping modulo 2^(ADDR_WIDTH+1).
- REQ-018: Read accepted iff rd_en && !empty; rd_ptr (ADDR_WIDTH+1 bits) increments with the same wrap.
- REQ-019: empty = (wr_ptr == rd_ptr); full = MSBs differ and lower ADDR_WIDTH bits equal; both decoded from registered pointers.
- REQ-020: count = wr_ptr - rd_ptr modulo 2^(ADDR_WIDTH+1); almost_full = (count >= AF_LEVEL); almost_empty = (count <= AE_LEVEL).
- REQ-021: All flags and count reflect an accepted operation in the cycle after its clock edge.
- REQ-022: Simultaneous read and write, neither full nor empty: both accepted, count unchanged.
- REQ-023: Both requested while full: read accepted, write dropped; while empty: write accepted, read dropped.
- REQ-024: overflow sets on wr_en && full; underflow sets on rd_en && empty; both hold until clr_err or reset; a set condition in the same cycle as clr_err wins.
- REQ-025: Non-FWFT mode: rd_data registered, updated one cycle after an accepted read; rd_valid pulses high for that one cycle; rd_data otherwise holds.
- REQ-026: Contents and order are preserved across pointer wrap-around with no gap or duplication.

Reset
- REQ-027: rst_n low at a clock edge SHALL clear wr_ptr, rd_ptr, rd_data, rd_valid, overflow and underflow to 0; contents are discarded, memory is not cleared.
- REQ-028: Post-reset: empty=1, full=0, count=0, almost_empty=1, almost_full=0; reset mid-operation overrides any concurrent read or write.

Configuration
- REQ-029: With macro FIFO_SYNC_PARAM_FWFT_EN defined: first-word fall-through; rd_data = mem[rd_ptr] whenever !empty; rd_valid = !empty; rd_en pops the presented word.
- REQ-030: Without FIFO_SYNC_PARAM_FWFT_EN: registered read per REQ-025.

Structure
- REQ-031: Package fifo_pkg SHALL hold default DATA_WIDTH and ADDR_WIDTH constants and the pointer-width expression.
- REQ-032: Storage SHALL be sub-module fifo_sync_mem: one write port, one asynchronous read port, no reset.
- REQ-033: Elaboration SHALL fail unless ADDR_WIDTH >= 1 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2)
- REQ-034: Write 0x01..0x08, then one more write of 0xFF -> full=1, count=8, overflow=1, 0xFF absent; read all 8 -> 0x01..0x08 in order, then empty=1.
- REQ-035: Fill to 5 then to 6 -> almost_full 0 at count 5, 1 at count 6; drain to 2 -> almost_empty=1 at count 2.
- REQ-036: Run 20 writes and 20 reads interleaved at half occupancy -> pointers wrap, data order exact, count constant during concurrent read/write cycles.
- REQ-037: rd_en when empty -> underflow=1, rd_valid=0; clr_err -> underflow=0 next cycle; clr_err together with a new underflow -> underflow stays 1.
- REQ-038: Write 3 words, assert rst_n low for one cycle during a concurrent write -> empty=1, count=0, errors 0; next write/read returns the new word only.
- REQ-039: FWFT build: write 0xA5 -> rd_data=0xA5, rd_valid=1 one cycle later without rd_en; rd_en -> empty=1 next cycle.
